// File: rtl/frodo_top.sv
// Frodo compute core: 2-stage instruction pipeline over a 16x16 register file and scratch memory.
// Optional feature: define FRODO_MAC_EN to execute opcode 101 as multiply-accumulate.
module frodo_top #(
    parameter int INST_WIDTH = 27,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    output logic                  wb_valid,
    output logic [3:0]            wb_index,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  illegal,
    output logic [15:0]           inst_count
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOADI = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_MAC   = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_LOAD  = 3'b111;

    // Decode of the incoming instruction
    logic                  w_accept;
    logic [2:0]            w_op;
    logic [3:0]            w_a;
    logic [3:0]            w_b;
    logic [3:0]            w_c;
    logic [11:0]           w_imm;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign inst_ready = ~rst;
    assign w_accept   = inst_valid & inst_ready;
    assign w_op       = inst[26:24];
    assign w_a        = inst[23:20];
    assign w_b        = inst[19:16];
    assign w_c        = inst[15:12];
    assign w_imm      = inst[11:0];
    assign w_addr     = inst[ADDR_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] r_regs [16];
    logic [DATA_WIDTH-1:0] r_mem  [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_mem_q;

    logic                  r_s1_valid;
    logic [2:0]            r_s1_op;
    logic [3:0]            r_s1_c;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;
    logic [11:0]           r_s1_imm;
`ifdef FRODO_MAC_EN
    logic [DATA_WIDTH-1:0] r_s1_acc;
`endif

    logic                  r_wb_valid;
    logic [3:0]            r_wb_index;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_illegal;
    logic [15:0]           r_inst_count;

    // Second stage: result of the instruction held in the stage register
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_illegal;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_wr_en   = 1'b0;
        w_wr_data = '0;
        w_illegal = 1'b0;
        if (r_s1_valid) begin
            case (r_s1_op)
                OP_LOADI: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = {{(DATA_WIDTH-12){1'b0}}, r_s1_imm};
                end
                OP_ADD: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = r_s1_a + r_s1_b;
                end
                OP_SUB: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = r_s1_a - r_s1_b;
                end
                OP_MUL: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = r_s1_a * r_s1_b;
                end
                OP_MAC: begin
`ifdef FRODO_MAC_EN
                    w_wr_en   = 1'b1;
                    w_wr_data = r_s1_acc + r_s1_a * r_s1_b;
`else
                    w_illegal = 1'b1;
`endif
                end
                OP_LOAD: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = r_mem_q;
                end
                default: ;
            endcase
        end
    end

    // Operand reads see the value being written at the same edge
    logic [DATA_WIDTH-1:0] w_a_val;
    logic [DATA_WIDTH-1:0] w_b_val;
    assign w_a_val = (w_wr_en && r_s1_c == w_a) ? w_wr_data : r_regs[w_a];
    assign w_b_val = (w_wr_en && r_s1_c == w_b) ? w_wr_data : r_regs[w_b];
`ifdef FRODO_MAC_EN
    logic [DATA_WIDTH-1:0] w_c_val;
    assign w_c_val = (w_wr_en && r_s1_c == w_c) ? w_wr_data : r_regs[w_c];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[r_s1_c] <= w_wr_data;
        end
    end

    // NOTE: the scratch memory has no reset branch; contents survive rst and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_accept && w_op == OP_STORE) r_mem[w_addr] <= w_a_val;
        if (w_accept && w_op == OP_LOAD)  r_mem_q       <= r_mem[w_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_op      <= OP_NOP;
            r_s1_c       <= '0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_imm     <= '0;
`ifdef FRODO_MAC_EN
            r_s1_acc     <= '0;
`endif
            r_wb_valid   <= 1'b0;
            r_wb_index   <= '0;
            r_wb_data    <= '0;
            r_illegal    <= 1'b0;
            r_inst_count <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op      <= w_op;
                r_s1_c       <= w_c;
                r_s1_a       <= w_a_val;
                r_s1_b       <= w_b_val;
                r_s1_imm     <= w_imm;
`ifdef FRODO_MAC_EN
                r_s1_acc     <= w_c_val;
`endif
                r_inst_count <= r_inst_count + 16'd1;
            end
            r_wb_valid <= w_wr_en;
            r_illegal  <= w_illegal;
            if (w_wr_en) begin
                r_wb_index <= r_s1_c;
                r_wb_data  <= w_wr_data;
            end
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_index   = r_wb_index;
    assign wb_data    = r_wb_data;
    assign illegal    = r_illegal;
    assign inst_count = r_inst_count;

endmodule

// File: tb/tb_frodo_top.sv
// Scoreboard bench for frodo_top: a sequential instruction model predicts each writeback trace entry.
// Honours FRODO_MAC_EN the same way the design does.
module tb_frodo_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        wb_valid;
    logic [3:0]  wb_index;
    logic [15:0] wb_data;
    logic        illegal;
    logic [15:0] inst_count;

    frodo_top dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .wb_valid   (wb_valid),
        .wb_index   (wb_index),
        .wb_data    (wb_data),
        .illegal    (illegal),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        valid;
        logic        ill;
        logic [3:0]  idx;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] m_regs [16];
    logic [15:0] m_mem [int];
    int          m_accepts = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [26:0] mk(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [11:0] imm);
        return {op, a, b, c, imm};
    endfunction

    // Architectural model: instructions take effect one at a time, in order
    task automatic model_exec(input logic [26:0] w);
        exp_t   e;
        int     op   = int'(w[26:24]);
        longint ra   = longint'(m_regs[w[23:20]]);
        longint rb   = longint'(m_regs[w[19:16]]);
        longint rc   = longint'(m_regs[w[15:12]]);
        int     addr = int'(w[11:0]);
        longint res  = 0;
        e.due = cyc + 1; e.valid = 1'b0; e.ill = 1'b0; e.idx = w[15:12]; e.data = '0;
        m_accepts++;
        case (op)
            1: begin e.valid = 1'b1; res = longint'(w[11:0]); end
            2: begin e.valid = 1'b1; res = (ra + rb) % 65536; end
            3: begin e.valid = 1'b1; res = (ra - rb + 65536) % 65536; end
            4: begin e.valid = 1'b1; res = (ra * rb) % 65536; end
            5: begin
`ifdef FRODO_MAC_EN
                e.valid = 1'b1; res = (rc + ra * rb) % 65536;
`else
                e.ill = 1'b1;
`endif
            end
            6: m_mem[addr] = m_regs[w[23:20]];
            7: begin e.valid = 1'b1; res = longint'(m_mem[addr]); end
            default: ;
        endcase
        e.data = res[15:0];
        if (e.valid) m_regs[w[15:12]] = e.data;
        if (e.valid || e.ill) sbq.push_back(e);
    endtask

    task automatic issue(input logic [26:0] w);
        inst = w;
        inst_valid = 1'b1;
        @(posedge clk);
        #2;
        model_exec(w);
        inst_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            inst = 27'($urandom);
            inst_valid = 1'b0;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        inst_valid = 1'b0;
        sbq.delete();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_accepts = 0;
        repeat (n) @(posedge clk);
        #2;
        check("rst_ready", 32'(inst_ready), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_count", 32'(inst_count), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check("ready_after_rst", 32'(inst_ready), 32'd1);
    endtask

    // Monitor: compares the writeback trace and instruction count every cycle
    initial begin
        exp_t        e;
        logic [21:0] act_w;
        logic [21:0] exp_w;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                e.due = cyc; e.valid = 1'b0; e.ill = 1'b0; e.idx = '0; e.data = '0;
                if (sbq.size() > 0 && sbq[0].due == cyc) e = sbq.pop_front();
                act_w = {wb_valid, illegal, wb_valid ? {wb_index, wb_data} : 20'h0};
                exp_w = {e.valid, e.ill, e.valid ? {e.idx, e.data} : 20'h0};
                check("wb_trace", 32'(act_w), 32'(exp_w));
                check("inst_count", 32'(inst_count), 32'(m_accepts[15:0]));
            end
        end
    end

    initial begin
        do_reset(5);

        // Every register reads zero out of reset
        for (int k = 0; k < 16; k++) issue(mk(3'b010, 4'(k), 4'd0, 4'd15, 12'h0));

        // Back-to-back dependent chain through the bypass
        issue(mk(3'b001, 4'd0, 4'd0, 4'd1, 12'hFFF));
        issue(mk(3'b001, 4'd0, 4'd0, 4'd2, 12'h001));
        issue(mk(3'b010, 4'd1, 4'd2, 4'd3, 12'h0));

        // R1 = 0x8000 by doubling, R2 = 2; truncating MUL and wrapping SUB
        issue(mk(3'b001, 4'd0, 4'd0, 4'd1, 12'h800));
        for (int k = 0; k < 4; k++) issue(mk(3'b010, 4'd1, 4'd1, 4'd1, 12'h0));
        issue(mk(3'b001, 4'd0, 4'd0, 4'd2, 12'h002));
        issue(mk(3'b100, 4'd1, 4'd2, 4'd4, 12'h0));
        issue(mk(3'b011, 4'd2, 4'd1, 4'd5, 12'h0));

        // STORE then LOAD of the same address on the next cycle
        issue(mk(3'b110, 4'd3, 4'd0, 4'd0, 12'hABC));
        issue(mk(3'b111, 4'd0, 4'd0, 4'd6, 12'hABC));

        // MAC, then read the accumulator register back
        issue(mk(3'b001, 4'd0, 4'd0, 4'd7, 12'd3));
        issue(mk(3'b001, 4'd0, 4'd0, 4'd8, 12'd5));
        issue(mk(3'b001, 4'd0, 4'd0, 4'd9, 12'd10));
        issue(mk(3'b101, 4'd7, 4'd8, 4'd9, 12'h0));
        issue(mk(3'b010, 4'd9, 4'd0, 4'd10, 12'h0));
        idle(2);

        // Randomised mix; memory traffic confined to a pre-initialised address pool
        for (int k = 0; k < 16; k++) issue(mk(3'b110, 4'(k), 4'd0, 4'd0, 12'(k)));
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                logic [2:0]  op  = 3'($urandom);
                logic [11:0] imm = 12'($urandom);
                if (op == 3'b110 || op == 3'b111) imm = 12'($urandom_range(0, 15));
                issue(mk(op, 4'($urandom), 4'($urandom), 4'($urandom), imm));
            end
        end
        idle(2);

        // Reset while an ADD is in flight: no writeback, destination cleared
        issue(mk(3'b001, 4'd0, 4'd0, 4'd12, 12'h123));
        issue(mk(3'b010, 4'd12, 4'd12, 4'd13, 12'h0));
        do_reset(2);
        issue(mk(3'b010, 4'd13, 4'd0, 4'd14, 12'h0));
        issue(mk(3'b010, 4'd12, 4'd0, 4'd14, 12'h0));
        idle(2);

        // Instruction counter wrap
        do_reset(1);
        for (int n = 0; n < 65535; n++) issue(27'h0);
        check("count_ffff", 32'(inst_count), 32'h0000FFFF);
        issue(27'h0);
        check("count_wrap", 32'(inst_count), 32'h0);
        idle(3);
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
